// File: rtl/uart_transmitter.sv
// UART transmitter: valid/ready push into a small FIFO, frames serialised LSB first on TXserial.
// Optional parity bit is built in when the UART_TX_PARITY_EN macro is defined.
module uart_transmitter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       TXserial,
  output logic                       tx_busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = $clog2(DEPTH + 1);
  localparam int unsigned StopClks = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned BaudW    = $clog2(StopClks);
  localparam int unsigned BitW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BaudW-1:0] BitLast   = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0] StopLast  = BaudW'(StopClks - 1);
  localparam logic [BitW-1:0]  LastBit   = BitW'(WIDTH - 1);
  localparam logic [CntW-1:0]  CountFull = CntW'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  state_e           r_state;
  logic [BaudW-1:0] r_baud;
  logic [BitW-1:0]  r_bitcnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_tx;
`ifdef UART_TX_PARITY_EN
  logic             r_parity;
`else
  logic             w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
`endif

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_shift_next;

  always_comb begin
    tx_ready     = (r_count != CountFull);
    w_push       = tx_valid && tx_ready;
    // The FSM pops only from IDLE or at the very last cycle of the stop phase.
    w_pop        = (r_count != '0) &&
                   ((r_state == StIdle) || ((r_state == StStop) && (r_baud == StopLast)));
    w_head       = r_mem[r_rptr];
    w_shift_next = r_shift >> 1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_state  <= StStart;
            r_shift  <= w_head;
            r_bitcnt <= '0;
            r_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= (^w_head) ^ PARITY_ODD;
`endif
          end
        end
        StStart: begin
          if (r_baud == BitLast) begin
            r_state <= StData;
            r_baud  <= '0;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
        StData: begin
          if (r_baud == BitLast) begin
            r_baud  <= '0;
            r_shift <= w_shift_next;
            if (r_bitcnt == LastBit) begin
              r_bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
              r_state  <= StParity;
              r_tx     <= r_parity;
`else
              r_state  <= StStop;
              r_tx     <= 1'b1;
`endif
            end else begin
              r_bitcnt <= r_bitcnt + BitW'(1);
              r_tx     <= w_shift_next[0];
            end
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (r_baud == BitLast) begin
            r_state <= StStop;
            r_baud  <= '0;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
`endif
        StStop: begin
          if (r_baud == StopLast) begin
            r_baud <= '0;
            // Queued word: go straight to the next start bit with no idle gap.
            if (w_pop) begin
              r_state  <= StStart;
              r_shift  <= w_head;
              r_bitcnt <= '0;
              r_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
              r_parity <= (^w_head) ^ PARITY_ODD;
`endif
            end else begin
              r_state <= StIdle;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign TXserial   = r_tx;
  assign tx_busy    = (r_state != StIdle);
  assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: u_dut1 (1 stop bit, even parity), u_dut2 (2 stop, odd).
// Parity expectations follow the UART_TX_PARITY_EN macro used for the build.
module tb_uart_transmitter;

  localparam int unsigned Cpb = 4;

  logic       clk;
  logic       reset;
  logic [7:0] d1, d2;
  logic       v1, v2;
  logic       ready1, ser1, busy1;
  logic       ready2, ser2, busy2;
  logic [2:0] cnt1, cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  uart_transmitter #(
    .WIDTH(8), .DEPTH(4), .CLKS_PER_BIT(Cpb), .STOP_BITS(1), .PARITY_ODD(1'b0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v1), .tx_ready(ready1),
    .TXserial(ser1), .tx_busy(busy1), .fifo_count(cnt1)
  );

  uart_transmitter #(
    .WIDTH(8), .DEPTH(4), .CLKS_PER_BIT(Cpb), .STOP_BITS(2), .PARITY_ODD(1'b1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .tx_data(d2), .tx_valid(v2), .tx_ready(ready2),
    .TXserial(ser2), .tx_busy(busy2), .fifo_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;    // line bits in send order from bit 0: start, data LSB first, stop
    logic       par_even;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin d2 = d; v2 = 1'b1; end
    else     begin d1 = d; v1 = 1'b1; end
    @(posedge clk);
    #1;
    // Scribble the data bus to show queued words are captured.
    if (sel) begin v2 = 1'b0; d2 = 8'hEE; end
    else     begin v1 = 1'b0; d1 = 8'hEE; end
  endtask

  // Waits for the start bit, then checks every cycle of every bit (line and tx_busy).
  task automatic check_frame(input bit sel, input logic [9:0] frame, input logic pe,
                             input string name, output int waited);
    logic [15:0] bits;
    logic [1:0]  act, exp;
    logic        line;
    int          n;
    bits = '1;
    for (int i = 0; i < 9; i++) bits[i] = frame[i];
    n = 9;
`ifdef UART_TX_PARITY_EN
    bits[n] = sel ? ~pe : pe;
    n++;
`endif
    n += sel ? 2 : 1;
    waited = 0;
    line = 1'b1;
    while (line && waited < 400) begin
      @(negedge clk);
      waited++;
      line = sel ? ser2 : ser1;
    end
    if (line) begin
      check($sformatf("%s start timeout", name), 32'(line), 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp = {1'b1, bits[i]};
      act = exp;
      for (int c = 0; c < Cpb; c++) begin
        if (!(i == 0 && c == 0)) @(negedge clk);
        if ({(sel ? busy2 : busy1), (sel ? ser2 : ser1)} !== exp && act === exp)
          act = {(sel ? busy2 : busy1), (sel ? ser2 : ser1)};
      end
      check($sformatf("%s bit%0d {busy,line}", name, i), 32'(act), 32'(exp));
    end
  endtask

  vec_t tbl[5];
  logic [7:0] words[6];
  logic [7:0] words_par;
  int   w;
  int   idx;
  logic acc;
  logic ok;

  initial begin
    tbl[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    tbl[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
    tbl[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
    tbl[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    tbl[4] = '{8'h01, 10'b1_00000001_0, 1'b1};
    words  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    words_par = 8'h00;  // all six words have an even number of ones

    reset = 1'b0;
    v1 = 1'b0; v2 = 1'b0; d1 = 8'h00; d2 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset dut1 {ready,line,busy,cnt}", {ready1, ser1, busy1, cnt1}, 6'b110_000);
    check("reset dut2 {ready,line,busy,cnt}", {ready2, ser2, busy2, cnt2}, 6'b110_000);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames, latency and return to idle.
    for (int r = 0; r < 5; r++) begin
      push(1'b0, tbl[r].data);
      check($sformatf("vec%0d count after push", r), 32'(cnt1), 32'd1);
      check_frame(1'b0, tbl[r].frame, tbl[r].par_even, $sformatf("vec%0d", r), w);
      check($sformatf("vec%0d start latency", r), 32'(w), 32'd2);
      @(negedge clk);
      check($sformatf("vec%0d idle {busy,line,cnt}", r), {busy1, ser1, cnt1}, 5'b0_1_000);
    end

    // Two words on consecutive edges: second push coincides with the first pop.
    push(1'b0, 8'h3C);
    check("b2b count after push1", 32'(cnt1), 32'd1);
    push(1'b0, 8'hFF);
    check("b2b count after push2+pop", 32'(cnt1), 32'd1);
    check_frame(1'b0, 10'b1_00111100_0, 1'b0, "b2b f0", w);
    check("b2b count end of f0", 32'(cnt1), 32'd1);
    check_frame(1'b0, 10'b1_11111111_0, 1'b0, "b2b f1", w);
    check("b2b no gap", 32'(w), 32'd1);
    check("b2b count end of f1", 32'(cnt1), 32'd0);
    @(negedge clk);
    check("b2b idle {busy,line}", {busy1, ser1}, 2'b01);

    // Hold valid with six words: five fit (one in flight, four queued).
    idx = 0;
    fork
      begin
        for (int cyc = 0; cyc < 10; cyc++) begin
          @(negedge clk);
          if (cyc == 6) check("full {ready,cnt}", {ready1, cnt1}, 4'b0_100);
          v1  = (idx < 6);
          d1  = words[(idx < 6) ? idx : 5];
          acc = v1 && ready1;
          @(posedge clk);
          if (acc) idx++;
        end
        @(negedge clk);
        v1 = 1'b0;
        check("words accepted", 32'(idx), 32'd5);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          check_frame(1'b0, {1'b1, words[k], 1'b0}, ^words_par, $sformatf("fill f%0d", k), w);
          if (k > 0) check($sformatf("fill f%0d no gap", k), 32'(w), 32'd1);
        end
      end
    join
    @(negedge clk);
    check("fill drained {busy,line,cnt}", {busy1, ser1, cnt1}, 5'b0_1_000);

    // Two stop bits on u_dut2, followed directly by the next frame.
    push(1'b1, 8'h55);
    push(1'b1, 8'h81);
    check_frame(1'b1, 10'b1_01010101_0, 1'b0, "stop2 f0", w);
    check_frame(1'b1, 10'b1_10000001_0, 1'b0, "stop2 f1", w);
    check("stop2 next start right after stop", 32'(w), 32'd1);
    @(negedge clk);
    check("stop2 idle {busy,line,cnt}", {busy2, ser2, cnt2}, 5'b0_1_000);

    // Asynchronous reset in the middle of a 0x00 data phase.
    push(1'b0, 8'h00);
    push(1'b0, 8'h5A);
    repeat (14) @(negedge clk);
    check("pre-reset mid data {busy,line,cnt}", {busy1, ser1, cnt1}, 5'b1_0_001);
    #2;
    reset = 1'b0;
    #1;
    check("async reset {ready,line,busy,cnt}", {ready1, ser1, busy1, cnt1}, 6'b110_000);
    @(negedge clk);
    reset = 1'b1;
    ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (ser1 !== 1'b1 || busy1 !== 1'b0) ok = 1'b0;
    end
    check("line stays idle after reset", 32'(ok), 32'd1);

    push(1'b0, tbl[0].data);
    check_frame(1'b0, tbl[0].frame, tbl[0].par_even, "post-reset", w);
    check("post-reset latency", 32'(w), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
